// File: rtl/ysyx_23060025_bus_arbiter_if.sv
// Request/response bus bundle shared by the IFU, the LSU and the downstream port of
// ysyx_23060025_bus_arbiter.
//   master : drives the request fields (paddr/psel/pwrite/psize/pwdata/pwstrb) and
//            receives the response (prdata/pvalid).
//   slave  : receives the request and drives the response.
// Parameters: DATA_LEN (data width), ADDR_LEN (address width).
interface ysyx_23060025_bus_arbiter_if #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0] paddr;
  logic                psel;
  logic                pwrite;
  logic [2:0]          psize;
  logic [DATA_LEN-1:0] pwdata;
  logic [3:0]          pwstrb;
  logic [DATA_LEN-1:0] prdata;
  logic                pvalid;

  modport master (
    output paddr, psel, pwrite, psize, pwdata, pwstrb,
    input  prdata, pvalid
  );

  modport slave (
    input  paddr, psel, pwrite, psize, pwdata, pwstrb,
    output prdata, pvalid
  );
endinterface

// File: rtl/ysyx_23060025_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory port between the IFU (read-only)
// and the LSU (read/write). One outstanding transaction at a time; the response is
// steered back combinationally to the requester that owns the transaction.
// Ports:
//   clock, rstn   : clock (rising edge) and asynchronous active-low reset
//   ifu_io        : IFU request/response (slave side; only paddr/psel are used)
//   lsu_io        : LSU request/response (slave side)
//   mem_io        : downstream request/response (master side)
//   arb_grant_o   : {lsu, ifu} owner of the current transaction, one-hot or 0
//   arb_timeout_o : sticky watchdog error
// Optional feature: define ARB_TIMEOUT_EN to enable the BUSY watchdog
// (TIMEOUT_CYCLES); otherwise BUSY waits indefinitely and arb_timeout_o is 0.
module ysyx_23060025_bus_arbiter #(
  parameter int unsigned DATA_LEN       = 32,
  parameter int unsigned ADDR_LEN       = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                               clock,
  input  logic                               rstn,
  ysyx_23060025_bus_arbiter_if.slave         ifu_io,
  ysyx_23060025_bus_arbiter_if.slave         lsu_io,
  ysyx_23060025_bus_arbiter_if.master        mem_io,
  output logic [1:0]                         arb_grant_o,
  output logic                               arb_timeout_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              state_q;
  logic [1:0]          grant_q;      // {lsu, ifu}
  logic                last_lsu_q;   // 1: LSU owned the last transaction
  logic                psel_q;
  logic [ADDR_LEN-1:0] paddr_q;
  logic                pwrite_q;
  logic [2:0]          psize_q;
  logic [DATA_LEN-1:0] pwdata_q;
  logic [3:0]          pwstrb_q;

  logic lsu_win;
  logic ifu_win;
  logic done;
  logic expire;

  // LSU wins when alone, or on a tie when the IFU was served last.
  assign lsu_win = lsu_io.psel & (~ifu_io.psel | ~last_lsu_q);
  assign ifu_win = ifu_io.psel & ~lsu_win;
  assign done    = (state_q == StBusy) & mem_io.pvalid;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      grant_q    <= 2'b00;
      last_lsu_q <= 1'b0;
      psel_q     <= 1'b0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      psize_q    <= 3'b000;
      pwdata_q   <= '0;
      pwstrb_q   <= 4'b0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (lsu_win) begin
            paddr_q  <= lsu_io.paddr;
            pwrite_q <= lsu_io.pwrite;
            psize_q  <= lsu_io.psize;
            pwdata_q <= lsu_io.pwdata;
            pwstrb_q <= lsu_io.pwstrb;
            grant_q  <= 2'b10;
            psel_q   <= 1'b1;
            state_q  <= StBusy;
          end else if (ifu_win) begin
            // Fetches are always full-word reads.
            paddr_q  <= ifu_io.paddr;
            pwrite_q <= 1'b0;
            psize_q  <= 3'b010;
            pwdata_q <= '0;
            pwstrb_q <= 4'b1111;
            grant_q  <= 2'b01;
            psel_q   <= 1'b1;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          if (done || expire) begin
            last_lsu_q <= grant_q[1];
            grant_q    <= 2'b00;
            psel_q     <= 1'b0;
            state_q    <= StIdle;
          end
        end
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;

  // A response in the expiry cycle wins over the watchdog.
  assign expire = (state_q == StBusy) & ~mem_io.pvalid &
                  (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        cnt_q <= '0;
      end else if (!mem_io.pvalid) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign arb_timeout_o = timeout_q;
`else
  assign expire        = 1'b0;
  assign arb_timeout_o = 1'b0;
`endif

  assign mem_io.psel   = psel_q;
  assign mem_io.paddr  = paddr_q;
  assign mem_io.pwrite = pwrite_q;
  assign mem_io.psize  = psize_q;
  assign mem_io.pwdata = pwdata_q;
  assign mem_io.pwstrb = pwstrb_q;

  // Responses are combinational so the requester sees them in the same cycle.
  // A watchdog expiry pulses pvalid with zero data.
  assign ifu_io.pvalid = grant_q[0] & (done | expire);
  assign ifu_io.prdata = (grant_q[0] & done) ? mem_io.prdata : '0;
  assign lsu_io.pvalid = grant_q[1] & (done | expire);
  assign lsu_io.prdata = (grant_q[1] & done) ? mem_io.prdata : '0;

  assign arb_grant_o = grant_q;

endmodule
